l2_arbiter: RTL

- Sits directly upstream of the L2 cache controller.
- Merges the I-cache miss port (read-only) and the D-cache miss port (read/write) into the single L2 request port.
- Grants one requester per L2 transaction, latches its address and write data, and routes the L2 response and read line back to the winner only.
- The L2 side sees a stable, one-hot-legal request: at most one of l2_read or l2_write is high.

---
 rtl/l2_arbiter_pkg.sv | 27 ++
 rtl/l2_arbiter_if.sv | 45 ++++
 rtl/l2_arbiter_grant.sv | 29 ++
 rtl/l2_arbiter.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/l2_arbiter_pkg.sv
// Shared types for the L2 request arbiter: line/word types, FSM states and grant sources.
package l2_arbiter_pkg;

  localparam int LC3B_ADDR_W = 16;
  localparam int LC3B_LINE_W = 128;

  typedef logic [LC3B_ADDR_W-1:0] lc3b_word;
  typedef logic [LC3B_LINE_W-1:0] lc3b_cline;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    DONE    = 2'd3
  } lc3b_arb_state;

  typedef enum logic {
    ARB_I = 1'b0,
    ARB_D = 1'b1
  } lc3b_arb_src;

  // A D-side request is only meaningful when exactly one of read/write is set.
  function automatic logic d_req_legal(input logic rd, input logic wr);
    return rd ^ wr;
  endfunction

endpackage

// File: rtl/l2_arbiter_if.sv
// Bundle of I-side, D-side and L2-side signals around the arbiter.
// slave: the arbiter's view; master: the requesters plus L2 as seen from outside.
interface l2_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
);

  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic              i_resp;
  logic [LINE_W-1:0] i_rdata;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic              d_resp;
  logic [LINE_W-1:0] d_rdata;

  logic              l2_read;
  logic              l2_write;
  logic [ADDR_W-1:0] l2_address;
  logic [LINE_W-1:0] l2_wdata;
  logic              l2_resp;
  logic [LINE_W-1:0] l2_rdata;

  modport slave (
    input  i_read, i_address,
    input  d_read, d_write, d_address, d_wdata,
    input  l2_resp, l2_rdata,
    output i_resp, i_rdata,
    output d_resp, d_rdata,
    output l2_read, l2_write, l2_address, l2_wdata
  );

  modport master (
    output i_read, i_address,
    output d_read, d_write, d_address, d_wdata,
    output l2_resp, l2_rdata,
    input  i_resp, i_rdata,
    input  d_resp, d_rdata,
    input  l2_read, l2_write, l2_address, l2_wdata
  );

endinterface

// File: rtl/l2_arbiter_grant.sv
// Combinational grant pick between I and D requesters; zero latency, no state.
// L2_ARB_RR_EN selects round-robin on last_grant, otherwise fixed D-over-I priority.
module l2_arbiter_grant
  import l2_arbiter_pkg::*;
(
  input  logic        i_req,
  input  logic        d_req,
`ifdef L2_ARB_RR_EN
  input  lc3b_arb_src last_grant,
`endif
  output logic        gnt_vld,
  output lc3b_arb_src gnt_src
);

  always_comb begin
    gnt_vld = i_req | d_req;
    gnt_src = ARB_I;
    if (i_req && d_req) begin
`ifdef L2_ARB_RR_EN
      gnt_src = (last_grant == ARB_I) ? ARB_D : ARB_I;
`else
      gnt_src = ARB_D;
`endif
    end else if (d_req) begin
      gnt_src = ARB_D;
    end
  end

endmodule

// File: rtl/l2_arbiter.sv
// Merges I-cache and D-cache miss ports onto one L2 port; one grant per L2 transaction.
// Build option L2_ARB_RR_EN enables round-robin arbitration (default: fixed D-over-I).
module l2_arbiter
  import l2_arbiter_pkg::*;
#(
  parameter int ADDR_W = LC3B_ADDR_W,
  parameter int LINE_W = LC3B_LINE_W
) (
  input  logic         clk,
  input  logic         reset_n,
  l2_arbiter_if.slave  bus
);

  lc3b_arb_state     state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              op_wr_q;
  logic [LINE_W-1:0] i_rdata_q;
  logic [LINE_W-1:0] d_rdata_q;

  logic              i_req;
  logic              d_req;
  logic              gnt_vld;
  lc3b_arb_src       gnt_src;
  logic              take_grant;

  assign i_req      = bus.i_read;
  assign d_req      = d_req_legal(bus.d_read, bus.d_write);
  assign take_grant = (state == IDLE) && gnt_vld;

`ifdef L2_ARB_RR_EN
  lc3b_arb_src last_grant;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= ARB_I;
    end else if (take_grant) begin
      last_grant <= gnt_src;
    end
  end
`endif

  l2_arbiter_grant u_grant (
    .i_req      (i_req),
    .d_req      (d_req),
`ifdef L2_ARB_RR_EN
    .last_grant (last_grant),
`endif
    .gnt_vld    (gnt_vld),
    .gnt_src    (gnt_src)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Request fields are captured once at grant; requester changes during SERVE are ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      op_wr_q <= 1'b0;
    end else if (take_grant) begin
      if (gnt_src == ARB_D) begin
        addr_q  <= bus.d_address;
        wdata_q <= bus.d_wdata;
        op_wr_q <= bus.d_write;
      end else begin
        addr_q  <= bus.i_address;
        op_wr_q <= 1'b0;
      end
    end
  end

  // Each side's rdata holds the last line it was given while the other side is served.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      if (state == SERVE_I && bus.l2_resp) begin
        i_rdata_q <= bus.l2_rdata;
      end
      if (state == SERVE_D && bus.l2_resp) begin
        d_rdata_q <= bus.l2_rdata;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    bus.l2_read  = 1'b0;
    bus.l2_write = 1'b0;
    bus.i_resp   = 1'b0;
    bus.d_resp   = 1'b0;
    bus.i_rdata  = i_rdata_q;
    bus.d_rdata  = d_rdata_q;

    case (state)
      IDLE: begin
        if (gnt_vld) begin
          state_nxt = (gnt_src == ARB_D) ? SERVE_D : SERVE_I;
        end
      end
      SERVE_I: begin
        bus.l2_read  = ~op_wr_q;
        bus.l2_write = op_wr_q;
        if (bus.l2_resp) begin
          bus.i_resp  = 1'b1;
          bus.i_rdata = bus.l2_rdata;
          state_nxt   = DONE;
        end
      end
      SERVE_D: begin
        bus.l2_read  = ~op_wr_q;
        bus.l2_write = op_wr_q;
        if (bus.l2_resp) begin
          bus.d_resp  = 1'b1;
          bus.d_rdata = bus.l2_rdata;
          state_nxt   = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.l2_address = addr_q;
  assign bus.l2_wdata   = wdata_q;

  a_one_resp : assert property (@(posedge clk) disable iff (!reset_n)
    !(bus.i_resp && bus.d_resp));
  a_one_op : assert property (@(posedge clk) disable iff (!reset_n)
    !(bus.l2_read && bus.l2_write));

endmodule
